// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the digit-serial multiplier sequencer.
// Holds the digit width, the controller state encoding and a digit extractor.
package mult_seq_pkg;

    localparam int DIGIT_W = 4;
    localparam int MAX_W   = 64;

    typedef enum logic [1:0] {IDLE, MUL, DONE} mult_seq_state_t;

    // Operands are zero-extended to MAX_W so one helper serves every W.
    function automatic logic [DIGIT_W-1:0] digit(input logic [MAX_W-1:0] x, input int k);
        return x[DIGIT_W*k +: DIGIT_W];
    endfunction

endpackage

// File: rtl/mul4x4_unit.sv
// Combinational 4x4 -> 8-bit unsigned multiplier: AND array, two-level 3:2
// compressor tree, then a Kogge-Stone prefix adder for the final carry-propagate add.
module mul4x4_unit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] row0, row1, row2, row3;
    logic [7:0] sum1, carry1, sum2, carry2;
    logic [7:0] gen, prop, gen_lvl, prop_lvl, gen_nxt, prop_nxt, carries;

    always_comb begin
        row0 = {4'b0000, a & {4{b[0]}}};
        row1 = {4'b0000, a & {4{b[1]}}} << 1;
        row2 = {4'b0000, a & {4{b[2]}}} << 2;
        row3 = {4'b0000, a & {4{b[3]}}} << 3;

        // The product never exceeds 225, so dropping carries out of bit 7 is safe.
        sum1   = row0 ^ row1 ^ row2;
        carry1 = ((row0 & row1) | (row0 & row2) | (row1 & row2)) << 1;
        sum2   = sum1 ^ carry1 ^ row3;
        carry2 = ((sum1 & carry1) | (sum1 & row3) | (carry1 & row3)) << 1;
    end

    always_comb begin
        gen      = sum2 & carry2;
        prop     = sum2 ^ carry2;
        gen_lvl  = gen;
        prop_lvl = prop;
        gen_nxt  = gen;
        prop_nxt = prop;
        for (int lvl = 0; lvl < 3; lvl++) begin
            gen_nxt  = gen_lvl;
            prop_nxt = prop_lvl;
            for (int k = (1 << lvl); k < 8; k++) begin
                gen_nxt[k]  = gen_lvl[k] | (prop_lvl[k] & gen_lvl[k - (1 << lvl)]);
                prop_nxt[k] = prop_lvl[k] & prop_lvl[k - (1 << lvl)];
            end
            gen_lvl  = gen_nxt;
            prop_lvl = prop_nxt;
        end
        carries = {gen_lvl[6:0], 1'b0};
        p       = prop ^ carries;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Digit-serial W x W unsigned multiplier sequencer around one shared 4x4 multiplier.
// Optional macro MULT_SEQ_ZERO_SKIP_EN: a zero operand jumps straight to DONE with product 0.
module mult_seq_ctrl #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_p,
    output logic           busy
);

    import mult_seq_pkg::*;

    localparam int N     = W / DIGIT_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    mult_seq_state_t state, next_state;

    logic [W-1:0]       a_reg, b_reg;
    logic [2*W-1:0]     acc, acc_next, term;
    logic [IDX_W-1:0]   i_idx, j_idx;
    logic [DIGIT_W-1:0] digit_a, digit_b;
    logic [7:0]         pp;
    logic               last_pair;
    logic               zero_skip;

`ifdef MULT_SEQ_ZERO_SKIP_EN
    assign zero_skip = (in_a == '0) || (in_b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    assign last_pair = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);

    mul4x4_unit u_mul (
        .a (digit_a),
        .b (digit_b),
        .p (pp)
    );

    // Current digit pair, shifted into its weight 4*(i+j) and added to the running sum.
    always_comb begin
        digit_a  = digit(MAX_W'(a_reg), int'(i_idx));
        digit_b  = digit(MAX_W'(b_reg), int'(j_idx));
        term     = (2*W)'(pp) << (DIGIT_W * (int'(i_idx) + int'(j_idx)));
        acc_next = acc + term;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    next_state = zero_skip ? DONE : MUL;
                end
            end
            MUL: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last_pair) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // out_p is loaded only when a result completes so it stays put outside DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            out_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        acc   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                        if (zero_skip) begin
                            out_p <= '0;
                        end
                    end
                end
                MUL: begin
                    if (!abort) begin
                        acc <= acc_next;
                        if (j_idx == LAST_IDX) begin
                            j_idx <= '0;
                            i_idx <= i_idx + IDX_W'(1);
                        end else begin
                            j_idx <= j_idx + IDX_W'(1);
                        end
                        if (last_pair) begin
                            out_p <= acc_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed testbench for mult_seq_ctrl (W=8): latency, hold, back-to-back, abort,
// mid-operation reset, zero operand (MULT_SEQ_ZERO_SKIP_EN aware) and a random sweep.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    int tests;
    int errors;

    mult_seq_ctrl #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge; returns at the negedge after the handshake edge (cycle 1).
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (out_p !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_p got=%h exp=0000", out_p); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_max_operands;
        out_ready = 1'b1;
        start_op(8'hFF, 8'hFF);
        for (int c = 1; c <= 5; c++) begin
            tests++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL max_busy cycle=%0d got=%b exp=1", c, busy); end
            tests++; if (out_valid !== (c == 5)) begin errors++; $display("[TB] FAIL max_out_valid cycle=%0d got=%b exp=%b", c, out_valid, (c == 5)); end
            if (c == 5) begin
                tests++; if (out_p !== 16'hFE01) begin errors++; $display("[TB] FAIL max_out_p got=%h exp=fe01", out_p); end
            end
            @(negedge clk);
        end
        tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL max_busy_after got=%b exp=0", busy); end
        tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL max_in_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_hold;
        int cyc;
        out_ready = 1'b0;
        start_op(8'h3C, 8'hA5);
        wait_valid(cyc);
        tests++; if (cyc !== 5) begin errors++; $display("[TB] FAIL hold_latency got=%0d exp=5", cyc); end
        for (int k = 0; k < 10; k++) begin
            tests++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_out_valid k=%0d got=%b exp=1", k, out_valid); end
            tests++; if (out_p !== 16'h26AC) begin errors++; $display("[TB] FAIL hold_out_p k=%0d got=%h exp=26ac", k, out_p); end
            tests++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready k=%0d got=%b exp=0", k, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid got=%b exp=0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        out_ready = 1'b1;
        start_op(8'h12, 8'h34);
        wait_valid(cyc);
        tests++; if (cyc !== 5) begin errors++; $display("[TB] FAIL b2b_first_latency got=%0d exp=5", cyc); end
        tests++; if (out_p !== 16'h03A8) begin errors++; $display("[TB] FAIL b2b_first_p got=%h exp=03a8", out_p); end
        tests++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_bypass got=%b exp=0", in_ready); end
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_ready got=%b exp=1", in_ready); end
        start_op(8'h80, 8'h02);
        wait_valid(cyc);
        tests++; if (cyc !== 5) begin errors++; $display("[TB] FAIL b2b_second_latency got=%0d exp=5", cyc); end
        tests++; if (out_p !== 16'h0100) begin errors++; $display("[TB] FAIL b2b_second_p got=%h exp=0100", out_p); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drop_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_abort;
        int cyc;
        out_ready = 1'b1;
        start_op(8'hFF, 8'hFF);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 6; k++) begin
            tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_valid k=%0d got=%b exp=0", k, out_valid); end
            @(negedge clk);
        end
        start_op(8'h07, 8'h09);
        wait_valid(cyc);
        tests++; if (cyc !== 5) begin errors++; $display("[TB] FAIL abort_next_latency got=%0d exp=5", cyc); end
        tests++; if (out_p !== 16'h003F) begin errors++; $display("[TB] FAIL abort_next_p got=%h exp=003f", out_p); end
        @(negedge clk);
    endtask

    task automatic test_zero_operand;
        int cyc;
        int exp_lat;
`ifdef MULT_SEQ_ZERO_SKIP_EN
        exp_lat = 1;
`else
        exp_lat = 5;
`endif
        out_ready = 1'b1;
        start_op(8'h00, 8'hC3);
        wait_valid(cyc);
        tests++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid got=%b exp=1", out_valid); end
        tests++; if (cyc !== exp_lat) begin errors++; $display("[TB] FAIL zero_latency got=%0d exp=%0d", cyc, exp_lat); end
        tests++; if (out_p !== 16'h0000) begin errors++; $display("[TB] FAIL zero_p got=%h exp=0000", out_p); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        start_op(8'hFF, 8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got=%b exp=0", out_valid); end
        tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        tests++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_p !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_out_p got=%h exp=0000", out_p); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale k=%0d got=%b exp=0", k, out_valid); end
        end
    endtask

    task automatic test_random_sweep;
        int cyc;
        logic [7:0]  ra, rb;
        logic [15:0] exp_p;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            exp_p = 16'(ra) * 16'(rb);
            start_op(ra, rb);
            wait_valid(cyc);
            tests++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sweep_timeout n=%0d got=%b exp=1", n, out_valid); end
            tests++; if (out_p !== exp_p) begin errors++; $display("[TB] FAIL sweep_p n=%0d a=%h b=%h got=%h exp=%h", n, ra, rb, out_p, exp_p); end
            @(negedge clk);
        end
    endtask

    initial begin
        tests     = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        test_max_operands;
        test_hold;
        test_back_to_back;
        test_abort;
        test_zero_operand;
        test_reset_mid;
        test_random_sweep;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
